// File: rtl/bus_alu_unit_pkg.sv
// Shared constants for the Mini-SRC bus/ALU core: opcodes and bus encoder selects.
package bus_alu_unit_pkg;

  localparam int unsigned DataW = 32;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam logic [4:0] SEL_R0  = 5'd0,  SEL_R1  = 5'd1,  SEL_R2  = 5'd2,  SEL_R3  = 5'd3;
  localparam logic [4:0] SEL_R4  = 5'd4,  SEL_R5  = 5'd5,  SEL_R6  = 5'd6,  SEL_R7  = 5'd7;
  localparam logic [4:0] SEL_R8  = 5'd8,  SEL_R9  = 5'd9,  SEL_R10 = 5'd10, SEL_R11 = 5'd11;
  localparam logic [4:0] SEL_R12 = 5'd12, SEL_R13 = 5'd13, SEL_R14 = 5'd14, SEL_R15 = 5'd15;
  localparam logic [4:0] SEL_HI     = 5'd16;
  localparam logic [4:0] SEL_LO     = 5'd17;
  localparam logic [4:0] SEL_ZHIGH  = 5'd18;
  localparam logic [4:0] SEL_ZLOW   = 5'd19;
  localparam logic [4:0] SEL_PC     = 5'd20;
  localparam logic [4:0] SEL_MDR    = 5'd21;
  localparam logic [4:0] SEL_INPORT = 5'd22;
  localparam logic [4:0] SEL_CSE    = 5'd23;
  localparam logic [4:0] SEL_NONE   = 5'd31;

endpackage

// File: rtl/bus_alu.sv
// Combinational 64-bit-result ALU: A from Y, B from the bus; mul/div inline.
module bus_alu
  import bus_alu_unit_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  opcode_i,
  input  logic        inc_pc_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [4:0]         amt;
  logic [63:0]        prod;
  logic [63:0]        ror_w;
  logic [63:0]        rol_w;
  logic signed [31:0] quot;
  logic signed [31:0] rem;

  assign amt   = b_i[4:0];
  assign prod  = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign ror_w = {a_i, a_i} >> amt;
  assign rol_w = {a_i, a_i} << amt;
  // Verilog signed / and % already truncate toward zero with remainder sign of A.
  assign quot  = $signed(a_i) / $signed(b_i);
  assign rem   = $signed(a_i) % $signed(b_i);

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (inc_pc_i) begin
      lo_o = b_i + 32'd1;
    end else begin
      case (opcode_i)
        OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: lo_o = a_i + b_i;
        OP_SUB:          lo_o = a_i - b_i;
        OP_AND, OP_ANDI: lo_o = a_i & b_i;
        OP_OR, OP_ORI:   lo_o = a_i | b_i;
        OP_SHR:          lo_o = a_i >> amt;
        OP_SHRA:         lo_o = 32'($signed(a_i) >>> amt);
        OP_SHL:          lo_o = a_i << amt;
        OP_ROR:          lo_o = ror_w[31:0];
        OP_ROL:          lo_o = rol_w[63:32];
        OP_MUL: begin
          hi_o = prod[63:32];
          lo_o = prod[31:0];
        end
        OP_DIV: begin
          if (b_i == '0) begin
            hi_o = a_i;
            lo_o = '1;
          end else begin
            hi_o = rem;
            lo_o = quot;
          end
        end
        OP_NEG:  lo_o = -b_i;
        OP_NOT:  lo_o = ~b_i;
        default: lo_o = b_i;
      endcase
    end
  end

endmodule

// File: rtl/bus_encoder.sv
// 32-to-5 priority encoder: index of the highest set bit, SEL_NONE when empty.
module bus_encoder
  import bus_alu_unit_pkg::*;
(
  input  logic [31:0] in_i,
  output logic [4:0]  sel_o
);

  // Ascending scan so the highest set bit is the last to write.
  always_comb begin
    sel_o = SEL_NONE;
    for (int unsigned i = 0; i < 32; i++) begin
      if (in_i[i]) sel_o = 5'(i);
    end
  end

endmodule

// File: rtl/bus_alu_unit.sv
// Mini-SRC bus-and-arithmetic core: bus encoder/mux, ALU and the Y/Zhigh/Zlow registers.
module bus_alu_unit
  import bus_alu_unit_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] BusMuxIn_R0,
  input  logic [31:0] BusMuxIn_R1,
  input  logic [31:0] BusMuxIn_R2,
  input  logic [31:0] BusMuxIn_R3,
  input  logic [31:0] BusMuxIn_R4,
  input  logic [31:0] BusMuxIn_R5,
  input  logic [31:0] BusMuxIn_R6,
  input  logic [31:0] BusMuxIn_R7,
  input  logic [31:0] BusMuxIn_R8,
  input  logic [31:0] BusMuxIn_R9,
  input  logic [31:0] BusMuxIn_R10,
  input  logic [31:0] BusMuxIn_R11,
  input  logic [31:0] BusMuxIn_R12,
  input  logic [31:0] BusMuxIn_R13,
  input  logic [31:0] BusMuxIn_R14,
  input  logic [31:0] BusMuxIn_R15,
  input  logic [31:0] BusMuxIn_HI,
  input  logic [31:0] BusMuxIn_LO,
  input  logic [31:0] BusMuxIn_PC,
  input  logic [31:0] BusMuxIn_MDR,
  input  logic [31:0] BusMuxIn_InPort,
  input  logic [31:0] C_sign_extended,
  input  logic [15:0] R0_15_out,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        PCout,
  input  logic        MDRout,
  input  logic        InPortout,
  input  logic        Cout,
  input  logic        Yin,
  input  logic        Zhighin,
  input  logic        Zlowin,
  input  logic        IncPC,
  input  logic [4:0]  opcode,
  output logic [31:0] BusMuxOut,
  output logic [31:0] C_out_HI,
  output logic [31:0] C_out_LO,
  output logic [31:0] Y_q,
  output logic [31:0] Zhigh_q,
  output logic [31:0] Zlow_q
);

  logic [31:0] enc_in;
  logic [4:0]  sel;
  logic [31:0] gpr [16];
  logic [31:0] y_q, y_d, zhigh_q, zhigh_d, zlow_q, zlow_d;

  assign enc_in = {8'h00, Cout, InPortout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout,
                   R0_15_out};

  assign gpr[0]  = BusMuxIn_R0;
  assign gpr[1]  = BusMuxIn_R1;
  assign gpr[2]  = BusMuxIn_R2;
  assign gpr[3]  = BusMuxIn_R3;
  assign gpr[4]  = BusMuxIn_R4;
  assign gpr[5]  = BusMuxIn_R5;
  assign gpr[6]  = BusMuxIn_R6;
  assign gpr[7]  = BusMuxIn_R7;
  assign gpr[8]  = BusMuxIn_R8;
  assign gpr[9]  = BusMuxIn_R9;
  assign gpr[10] = BusMuxIn_R10;
  assign gpr[11] = BusMuxIn_R11;
  assign gpr[12] = BusMuxIn_R12;
  assign gpr[13] = BusMuxIn_R13;
  assign gpr[14] = BusMuxIn_R14;
  assign gpr[15] = BusMuxIn_R15;

  bus_encoder u_encoder (
    .in_i  (enc_in),
    .sel_o (sel)
  );

  always_comb begin
    BusMuxOut = '0;
    if (sel <= SEL_R15) begin
      BusMuxOut = gpr[sel[3:0]];
    end else begin
      case (sel)
        SEL_HI:     BusMuxOut = BusMuxIn_HI;
        SEL_LO:     BusMuxOut = BusMuxIn_LO;
        SEL_ZHIGH:  BusMuxOut = zhigh_q;
        SEL_ZLOW:   BusMuxOut = zlow_q;
        SEL_PC:     BusMuxOut = BusMuxIn_PC;
        SEL_MDR:    BusMuxOut = BusMuxIn_MDR;
        SEL_INPORT: BusMuxOut = BusMuxIn_InPort;
        SEL_CSE:    BusMuxOut = C_sign_extended;
        default:    BusMuxOut = '0;
      endcase
    end
  end

  bus_alu u_alu (
    .a_i      (y_q),
    .b_i      (BusMuxOut),
    .opcode_i (opcode),
    .inc_pc_i (IncPC),
    .hi_o     (C_out_HI),
    .lo_o     (C_out_LO)
  );

  always_comb begin
    y_d     = y_q;
    zhigh_d = zhigh_q;
    zlow_d  = zlow_q;
    if (Yin)     y_d     = BusMuxOut;
    if (Zhighin) zhigh_d = C_out_HI;
    if (Zlowin)  zlow_d  = C_out_LO;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      y_q     <= '0;
      zhigh_q <= '0;
      zlow_q  <= '0;
    end else begin
      y_q     <= y_d;
      zhigh_q <= zhigh_d;
      zlow_q  <= zlow_d;
    end
  end

  assign Y_q     = y_q;
  assign Zhigh_q = zhigh_q;
  assign Zlow_q  = zlow_q;

endmodule

// File: tb/tb_bus_alu_unit.sv
// Self-checking bench for bus_alu_unit: directed cases then random steps against a reference model.
module tb_bus_alu_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] r [16];
  logic [31:0] hi_in, lo_in, pc_in, mdr_in, inp_in, cse_in;
  logic [15:0] r_out;
  logic        hi_out, lo_out, zh_out, zl_out, pc_out, mdr_out, inp_out, c_out;
  logic        yin, zhin, zlin, incpc;
  logic [4:0]  opcode;
  logic [31:0] bus, c_hi, c_lo, y_q, zh_q, zl_q;
  logic [31:0] y_m, zh_m, zl_m;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clock = ~clock;

  bus_alu_unit dut (
    .clock(clock), .clear(clear),
    .BusMuxIn_R0(r[0]), .BusMuxIn_R1(r[1]), .BusMuxIn_R2(r[2]), .BusMuxIn_R3(r[3]),
    .BusMuxIn_R4(r[4]), .BusMuxIn_R5(r[5]), .BusMuxIn_R6(r[6]), .BusMuxIn_R7(r[7]),
    .BusMuxIn_R8(r[8]), .BusMuxIn_R9(r[9]), .BusMuxIn_R10(r[10]), .BusMuxIn_R11(r[11]),
    .BusMuxIn_R12(r[12]), .BusMuxIn_R13(r[13]), .BusMuxIn_R14(r[14]), .BusMuxIn_R15(r[15]),
    .BusMuxIn_HI(hi_in), .BusMuxIn_LO(lo_in), .BusMuxIn_PC(pc_in), .BusMuxIn_MDR(mdr_in),
    .BusMuxIn_InPort(inp_in), .C_sign_extended(cse_in),
    .R0_15_out(r_out), .HIout(hi_out), .LOout(lo_out), .Zhighout(zh_out), .Zlowout(zl_out),
    .PCout(pc_out), .MDRout(mdr_out), .InPortout(inp_out), .Cout(c_out),
    .Yin(yin), .Zhighin(zhin), .Zlowin(zlin), .IncPC(incpc), .opcode(opcode),
    .BusMuxOut(bus), .C_out_HI(c_hi), .C_out_LO(c_lo),
    .Y_q(y_q), .Zhigh_q(zh_q), .Zlow_q(zl_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sources listed lowest priority first; the last enabled one wins.
  function automatic logic [31:0] bus_ref();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) if (r_out[i]) v = r[i];
    if (hi_out)  v = hi_in;
    if (lo_out)  v = lo_in;
    if (zh_out)  v = zh_m;
    if (zl_out)  v = zl_m;
    if (pc_out)  v = pc_in;
    if (mdr_out) v = mdr_in;
    if (inp_out) v = inp_in;
    if (c_out)   v = cse_in;
    return v;
  endfunction

  function automatic void alu_ref(input logic [4:0] op, input logic inc, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] hi,
                                  output logic [31:0] lo);
    int     sa, sb, n;
    longint p;
    sa = a;
    sb = b;
    n  = int'(b[4:0]);
    hi = '0;
    if (inc) begin
      lo = b + 1;
      return;
    end
    case (op)
      0, 1, 2, 3, 12: lo = a + b;
      4:       lo = a - b;
      5, 13:   lo = a & b;
      6, 14:   lo = a | b;
      7:       lo = a >> n;
      8:       lo = sa >>> n;
      9:       lo = a << n;
      10:      lo = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
      11:      lo = (n == 0) ? a : ((a << n) | (a >> (32 - n)));
      15: begin
        p = longint'(sa) * longint'(sb);
        hi = p[63:32];
        lo = p[31:0];
      end
      16: begin
        if (b == 0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else begin
          lo = sa / sb;
          hi = sa % sb;
        end
      end
      17:      lo = 0 - b;
      18:      lo = ~b;
      default: lo = b;
    endcase
  endfunction

  task automatic idle();
    r_out = '0;
    {hi_out, lo_out, zh_out, zl_out, pc_out, mdr_out, inp_out, c_out} = '0;
    {yin, zhin, zlin, incpc} = '0;
    opcode = '0;
  endtask

  task automatic comb_check(input string tag);
    logic [31:0] b, h, l;
    #1;
    b = bus_ref();
    alu_ref(opcode, incpc, y_m, b, h, l);
    chk({tag, ".bus"}, bus, b);
    chk({tag, ".hi"}, c_hi, h);
    chk({tag, ".lo"}, c_lo, l);
  endtask

  task automatic clk_step(input string tag);
    logic [31:0] b, h, l;
    b = bus_ref();
    alu_ref(opcode, incpc, y_m, b, h, l);
    if (yin)  y_m  = b;
    if (zhin) zh_m = h;
    if (zlin) zl_m = l;
    @(posedge clock);
    #1;
    chk({tag, ".y"}, y_q, y_m);
    chk({tag, ".zh"}, zh_q, zh_m);
    chk({tag, ".zl"}, zl_q, zl_m);
  endtask

  task automatic load_y(input logic [31:0] val);
    @(negedge clock);
    idle();
    r[1]  = val;
    r_out = 16'h0002;
    yin   = 1'b1;
    clk_step("load_y");
    yin = 1'b0;
  endtask

  task automatic drive_b(input logic [31:0] val, input logic [4:0] op);
    @(negedge clock);
    idle();
    r[2]   = val;
    r_out  = 16'h0004;
    opcode = op;
    #1;
  endtask

  initial begin
    logic [23:0] en;
    clear = 1'b1;
    foreach (r[i]) r[i] = '0;
    {hi_in, lo_in, pc_in, mdr_in, inp_in, cse_in} = '0;
    idle();
    {y_m, zh_m, zl_m} = '0;
    #1;
    chk("rst.y", y_q, 32'h0);
    chk("rst.zh", zh_q, 32'h0);
    chk("rst.zl", zl_q, 32'h0);
    @(negedge clock);
    clear = 1'b0;

    drive_b(32'h1234_5678, 5'd0);
    chk("enc.r2", bus, 32'h1234_5678);
    idle();
    #1 chk("enc.none", bus, 32'h0);
    r[3] = 32'hAAAA_0003; mdr_in = 32'hBBBB_0021; r_out = 16'h0008; mdr_out = 1'b1;
    #1 chk("enc.mdr_wins", bus, 32'hBBBB_0021);

    load_y(32'd5);
    drive_b(32'd7, 5'b00011);   chk("add", c_lo, 32'd12);
    opcode = 5'b00100; #1       chk("sub", c_lo, 32'hFFFF_FFFE);
    drive_b(32'hFFFF_FFFF, 5'b00100);
    incpc = 1'b1; #1            chk("incpc.lo", c_lo, 32'h0);
                                chk("incpc.hi", c_hi, 32'h0);

    load_y(32'h8000_0001);
    drive_b(32'd1, 5'b01000);   chk("shra", c_lo, 32'hC000_0000);
    opcode = 5'b00111; #1       chk("shr", c_lo, 32'h4000_0000);
    opcode = 5'b01010; #1       chk("ror", c_lo, 32'hC000_0000);
    opcode = 5'b01011; #1       chk("rol", c_lo, 32'h0000_0003);

    load_y(32'hFFFF_FFFD);
    drive_b(32'd4, 5'b01111);   chk("mul.hi", c_hi, 32'hFFFF_FFFF);
                                chk("mul.lo", c_lo, 32'hFFFF_FFF4);
    load_y(32'hFFFF_FFF9);
    drive_b(32'd2, 5'b10000);   chk("div.lo", c_lo, 32'hFFFF_FFFD);
                                chk("div.hi", c_hi, 32'hFFFF_FFFF);
    load_y(32'd9);
    drive_b(32'd0, 5'b10000);   chk("div0.lo", c_lo, 32'hFFFF_FFFF);
                                chk("div0.hi", c_hi, 32'd9);

    load_y(32'd5);
    drive_b(32'd7, 5'b00011);
    zlin = 1'b1; zhin = 1'b1;
    chk("zl.before_edge", zl_q, 32'h0);
    clk_step("z_load");
    chk("zl.after_edge", zl_q, 32'd12);
    // Zlow feeds the bus and is reloaded in the same cycle.
    @(negedge clock);
    idle();
    zl_out = 1'b1; zlin = 1'b1; opcode = 5'b00011;
    #1 chk("zloop.lo", c_lo, 32'd17);
    clk_step("zloop");
    chk("zloop.zl", zl_q, 32'd17);

    @(negedge clock);
    idle();
    #2 clear = 1'b1;
    #1 chk("clr.y", y_q, 32'h0);
    chk("clr.zl", zl_q, 32'h0);
    chk("clr.zh", zh_q, 32'h0);
    {y_m, zh_m, zl_m} = '0;
    r[2] = 32'hDEAD_BEEF; r_out = 16'h0004; yin = 1'b1; zlin = 1'b1;
    @(posedge clock);
    #1 chk("clr.hold_y", y_q, 32'h0);
    chk("clr.hold_zl", zl_q, 32'h0);
    @(negedge clock);
    clear = 1'b0;
    idle();

    for (int it = 0; it < 80; it++) begin
      @(negedge clock);
      foreach (r[i]) r[i] = $urandom;
      {hi_in, lo_in, pc_in, mdr_in} = {$urandom, $urandom, $urandom, $urandom};
      {inp_in, cse_in} = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       en = '0;
        1:       en = 24'(1) << $urandom_range(0, 23);
        default: en = 24'($urandom & $urandom);
      endcase
      {c_out, inp_out, mdr_out, pc_out, zl_out, zh_out, lo_out, hi_out, r_out} = en;
      opcode = 5'($urandom_range(0, 31));
      incpc  = ($urandom_range(0, 7) == 0);
      if (opcode == 5'd16 && y_m == 32'h8000_0000 && bus_ref() == 32'hFFFF_FFFF) opcode = 5'd0;
      yin  = 1'($urandom);
      zhin = 1'($urandom);
      zlin = 1'($urandom);
      comb_check("rand");
      clk_step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
